tx_scheduler: RTL
=================

TX_SCHEDULER -- requirements
Module: tx_scheduler

Interface
REQ-001 Parameter NUM_REGS, default `__NUM_REGS: number of configuration registers dumped per conf packet.
REQ-002 Parameter DATA_WIDTH, default `__DATA_WIDTH: width of each configuration register.
REQ-003 Parameter TX_WIDTH, default `__TX_WIDTH: width of one transmitted word.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 conf_start  in  1  one-cycle pulse requesting a register dump.
REQ-007 conf_request  out  1  load strobe to the conf shift register.
REQ-008 conf_ack  out  1  shift strobe to the conf shift register.
REQ-009 conf_data  in  TX_WIDTH  current conf shift register word.
REQ-010 buf_valid  in  1  sample-buffer word available.
REQ-011 buf_data  in  TX_WIDTH  sample-buffer word.
REQ-012 buf_last  in  1  qualifies the final word of a buffer packet.
REQ-013 buf_ack  out  1  buffer word consumed.
REQ-014 tx_rdy  in  1  FT245 transmit side can accept a word.
REQ-015 tx_wr  out  1  tx_data valid.
REQ-016 tx_data  out  TX_WIDTH  word to the transmitter.
REQ-017 busy  out  1  high in any state other than ST_IDLE.

Function
REQ-018 A word SHALL transfer on every cycle with tx_wr=1 and tx_rdy=1; tx_data SHALL hold stable while tx_wr=1 and tx_rdy=0.
REQ-019 States: ST_IDLE, ST_HDR, ST_CONF_LOAD, ST_CONF_SEND, ST_BUF_SEND.
REQ-020 conf_start SHALL set a conf_pending flag in any state; the flag clears on entry to ST_CONF_LOAD; a pulse during a conf dump is kept for one further dump, not lost.
REQ-021 ST_IDLE: conf_pending has priority over buf_valid; if both are low, stay; a grant goes to ST_HDR (header enabled) or directly to the granted send path.
REQ-022 ST_CONF_LOAD: conf_request=1 for exactly one cycle, then ST_CONF_SEND.
REQ-023 ST_CONF_SEND: tx_wr=1, tx_data=conf_data, conf_ack=tx_rdy; a word counter loaded with CONF_WORDS = DATA_WIDTH/TX_WIDTH*NUM_REGS decrements per transfer; after the last transfer, go to ST_IDLE.
REQ-024 ST_BUF_SEND: tx_wr=buf_valid, tx_data=buf_data, buf_ack=buf_valid&tx_rdy; a transfer with buf_last=1 returns to ST_IDLE.
REQ-025 A granted packet SHALL never be preempted; conf_pending asserted mid-buffer-packet waits for buf_last.
REQ-026 conf_request, conf_ack and buf_ack SHALL be 0 in every state not named for them.
REQ-027 Back-to-back packets: ST_IDLE costs exactly one idle cycle between packets.

Reset
REQ-028 While rst=0: state=ST_IDLE, conf_pending=0, counter=CONF_WORDS, all outputs 0, tx_data=0.
REQ-029 Reset asserted mid-packet SHALL abort immediately; the scheduler issues no further ack for the aborted packet.

Configuration
REQ-030 With TX_SCHED_HEADER_EN defined, ST_HDR drives tx_wr=1 with tx_data=HDR_CONF or HDR_BUF until transferred, then enters the send state; without the macro, ST_HDR is absent and grants go straight to ST_CONF_LOAD/ST_BUF_SEND.

Structure
REQ-031 The state encodings, HDR_CONF (C0h), HDR_BUF (B0h) and the CONF_WORDS formula SHALL be in the shared defines file tx_sched_defines.v, next to conf_regs_defines.v.
REQ-032 Single module; no sub-module; the conf shift register and buffer stay external.

Verification (NUM_REGS=2, DATA_WIDTH=16, TX_WIDTH=8, header on)
REQ-033 conf_start, tx_rdy=1 -> C0h, then 4 conf words on consecutive cycles, 4 conf_ack pulses, busy drops.
REQ-034 buf_valid with 3 words (last on 3rd), tx_rdy toggling 1,0,1 -> B0h + 3 words, tx_data stable during stalls, buf_ack only when tx_rdy=1.
REQ-035 conf_start and buf_valid in the same cycle -> conf packet first, then buffer packet after 1 idle cycle.
REQ-036 conf_start during a buffer packet -> buffer completes through buf_last, then conf dump.
REQ-037 rst low during the 2nd conf word -> all outputs 0 asynchronously; after release, idle with busy=0.
REQ-038 Macro undefined, conf_start -> first transferred word is conf_data; no header.

Source files
------------

// File: rtl/tx_scheduler_pkg.sv
// Shared scheduler constants: state encodings, packet header bytes and the
// conf-dump word-count formula used by tx_scheduler.
package tx_scheduler_pkg;

  localparam int DEF_NUM_REGS   = 2;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_TX_WIDTH   = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HDR       = 3'd1,
    ST_CONF_LOAD = 3'd2,
    ST_CONF_SEND = 3'd3,
    ST_BUF_SEND  = 3'd4
  } state_t;

  localparam logic [7:0] HDR_CONF = 8'hC0;
  localparam logic [7:0] HDR_BUF  = 8'hB0;

  // Words needed to stream every configuration register through the TX port.
  function automatic int conf_words(input int num_regs, input int data_width,
                                    input int tx_width);
    return data_width / tx_width * num_regs;
  endfunction

endpackage

// File: rtl/tx_scheduler.sv
// Arbitrates a configuration-register dump and a sample-buffer stream onto one
// FT245-style TX port. Define TX_SCHED_HEADER_EN to prefix each packet with a header byte.
module tx_scheduler
  import tx_scheduler_pkg::*;
#(
  parameter int NUM_REGS   = DEF_NUM_REGS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TX_WIDTH   = DEF_TX_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                conf_start,
  output logic                conf_request,
  output logic                conf_ack,
  input  logic [TX_WIDTH-1:0] conf_data,
  input  logic                buf_valid,
  input  logic [TX_WIDTH-1:0] buf_data,
  input  logic                buf_last,
  output logic                buf_ack,
  input  logic                tx_rdy,
  output logic                tx_wr,
  output logic [TX_WIDTH-1:0] tx_data,
  output logic                busy
);

  localparam int CONF_WORDS = conf_words(NUM_REGS, DATA_WIDTH, TX_WIDTH);
  localparam int CNT_W      = $clog2(CONF_WORDS + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CONF_WORDS);

  state_t           state;
  state_t           state_nxt;
  logic             conf_pending;
  logic [CNT_W-1:0] word_cnt;

  logic conf_req;
  logic conf_grant;
  logic enter_load;
  logic xfer_conf;
  logic xfer_buf;
  logic last_conf;

  // A pulse arriving while idle is granted straight away, so it must not
  // also leave a pending request behind.
  assign conf_req   = conf_pending | conf_start;
  assign conf_grant = (state == ST_IDLE) && conf_req;
  assign enter_load = (state_nxt == ST_CONF_LOAD) && (state != ST_CONF_LOAD);
  assign xfer_conf  = (state == ST_CONF_SEND) && tx_rdy;
  assign xfer_buf   = (state == ST_BUF_SEND) && buf_valid && tx_rdy;
  assign last_conf  = xfer_conf && (word_cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

`ifdef TX_SCHED_HEADER_EN
  logic pkt_conf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_conf <= 1'b0;
    end else if (state == ST_IDLE) begin
      pkt_conf <= conf_req;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
`ifdef TX_SCHED_HEADER_EN
        if (conf_req || buf_valid) state_nxt = ST_HDR;
`else
        if (conf_req)       state_nxt = ST_CONF_LOAD;
        else if (buf_valid) state_nxt = ST_BUF_SEND;
`endif
      end
`ifdef TX_SCHED_HEADER_EN
      ST_HDR: begin
        if (tx_rdy) state_nxt = pkt_conf ? ST_CONF_LOAD : ST_BUF_SEND;
      end
`endif
      ST_CONF_LOAD: state_nxt = ST_CONF_SEND;
      ST_CONF_SEND: begin
        if (last_conf) state_nxt = ST_IDLE;
      end
      ST_BUF_SEND: begin
        if (xfer_buf && buf_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      conf_pending <= 1'b0;
    end else begin
      conf_pending <= (conf_start & ~conf_grant) | (conf_pending & ~enter_load);
    end
  end

  // Reloaded on the last word so the next dump always starts from a full count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_cnt <= CNT_LOAD;
    end else if ((state == ST_CONF_LOAD) || last_conf) begin
      word_cnt <= CNT_LOAD;
    end else if (xfer_conf) begin
      word_cnt <= word_cnt - CNT_W'(1);
    end
  end

  always_comb begin
    conf_request = 1'b0;
    conf_ack     = 1'b0;
    buf_ack      = 1'b0;
    tx_wr        = 1'b0;
    tx_data      = '0;
    case (state)
`ifdef TX_SCHED_HEADER_EN
      ST_HDR: begin
        tx_wr   = 1'b1;
        tx_data = pkt_conf ? TX_WIDTH'(HDR_CONF) : TX_WIDTH'(HDR_BUF);
      end
`endif
      ST_CONF_LOAD: conf_request = 1'b1;
      ST_CONF_SEND: begin
        tx_wr    = 1'b1;
        tx_data  = conf_data;
        conf_ack = tx_rdy;
      end
      ST_BUF_SEND: begin
        tx_wr   = buf_valid;
        tx_data = buf_data;
        buf_ack = buf_valid & tx_rdy;
      end
      default: ;
    endcase
  end

  assign busy = (state != ST_IDLE);

endmodule
